stack_reverser: RTL and testbench



---
 rtl/stack_reverser.sv | 97 +++++++++
 tb/tb_stack_reverser.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/stack_reverser.sv
// Frame-reversing buffer: fills a LIFO from an input stream, then drains it in reverse order.
// Frames longer than DEPTH are split into DEPTH-sized chunks, which raises the sticky split_err flag.
module stack_reverser #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             empty,
  output logic             full,
  output logic             split_err,
  output logic [7:0]       frame_cnt
);

  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_TOP  = (PTR_W+1)'(DEPTH - 1);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);

  state_t           state_q, state_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             split_err_q, split_err_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic             push;
  logic [PTR_W-1:0] rd_idx;

  logic [WIDTH-1:0] mem [DEPTH];

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    split_err_d = split_err_q;
    frame_cnt_d = frame_cnt_q;
    push        = 1'b0;
    case (state_q)
      FILL: begin
        if (in_valid) begin
          push    = 1'b1;
          count_d = count_q + CNT_ONE;
          // Reaching full ends the chunk even without in_last; the rest follows as a new frame.
          if (in_last || count_q == CNT_TOP) state_d = DRAIN;
          if (!in_last && count_q == CNT_TOP) split_err_d = 1'b1;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          count_d = count_q - CNT_ONE;
          if (count_q == CNT_ONE) begin
            state_d     = FILL;
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      count_q     <= '0;
      split_err_q <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      split_err_q <= split_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Storage is never reset; only the count decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[count_q[PTR_W-1:0]] <= in_data;
  end

  assign rd_idx    = count_q[PTR_W-1:0] - PTR_W'(1);
  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == DRAIN);
  assign out_data  = mem[rd_idx];
  assign out_last  = (state_q == DRAIN) && (count_q == CNT_ONE);
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_FULL);
  assign split_err = split_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_stack_reverser.sv
// Directed scenarios for stack_reverser: ordering, splitting, backpressure, reset and hold-off.
module tb_stack_reverser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready = 1'b0;
  logic       empty;
  logic       full;
  logic       split_err;
  logic [7:0] frame_cnt;

  int checks = 0;
  int failures = 0;

  stack_reverser #(.WIDTH(8), .DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .empty(empty), .full(full), .split_err(split_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic push(input logic [7:0] d, input logic l);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = l; out_ready = 1'b0;
    $display("push data=%h last=%0d", d, l);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_last = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL reset_flags got empty=%b full=%b exp empty=1 full=0", empty, full); end
    checks++; if (split_err !== 1'b0 || frame_cnt !== 8'd0) begin failures++; $display("FAIL reset_counters got split=%b frames=%0d exp 0 0", split_err, frame_cnt); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h33; exp_d[1] = 8'h22; exp_d[2] = 8'h11;
    do_reset();
    push(8'h11, 1'b0); push(8'h22, 1'b0); push(8'h33, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      $display("pop data=%h last=%0d valid=%0d", out_data, out_last, out_valid);
      checks++; if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_last !== (i == 2)) begin
        failures++; $display("FAIL basic_pop%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b", i, out_valid, out_data, out_last, exp_d[i], (i == 2));
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || empty !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL basic_after got rdy=%b empty=%b v=%b exp 1 1 0", in_ready, empty, out_valid); end
    checks++; if (frame_cnt !== 8'd1 || split_err !== 1'b0) begin failures++; $display("FAIL basic_counters got frames=%0d split=%b exp 1 0", frame_cnt, split_err); end
  endtask

  task automatic test_split();
    logic [7:0] exp_d [4];
    exp_d[0] = 8'h04; exp_d[1] = 8'h03; exp_d[2] = 8'h02; exp_d[3] = 8'h01;
    do_reset();
    push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'h03, 1'b0); push(8'h04, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h05; in_last = 1'b0; out_ready = 1'b0;
    checks++; if (full !== 1'b1 || split_err !== 1'b1) begin failures++; $display("FAIL split_full got full=%b split=%b exp 1 1", full, split_err); end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      out_ready = 1'b1;
      $display("pop data=%h last=%0d rdy=%0d", out_data, out_last, in_ready);
      checks++; if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_last !== (i == 3) || in_ready !== 1'b0) begin
        failures++; $display("FAIL split_pop%0d got v=%b d=%h l=%b rdy=%b exp v=1 d=%h l=%b rdy=0", i, out_valid, out_data, out_last, in_ready, exp_d[i], (i == 3));
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || empty !== 1'b1) begin failures++; $display("FAIL split_refill got rdy=%b empty=%b exp 1 1", in_ready, empty); end
    push(8'h06, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      $display("pop data=%h last=%0d", out_data, out_last);
      checks++; if (out_data !== ((i == 0) ? 8'h06 : 8'h05) || out_last !== (i == 1)) begin
        failures++; $display("FAIL split_second%0d got d=%h l=%b exp d=%h l=%b", i, out_data, out_last, ((i == 0) ? 8'h06 : 8'h05), (i == 1));
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (frame_cnt !== 8'd2 || split_err !== 1'b1) begin failures++; $display("FAIL split_counters got frames=%0d split=%b exp 2 1", frame_cnt, split_err); end
  endtask

  task automatic test_backpressure();
    do_reset();
    push(8'hA0, 1'b0); push(8'hB0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      $display("stall cycle=%0d data=%h valid=%0d last=%0d", i, out_data, out_valid, out_last);
      checks++; if (out_valid !== 1'b1 || out_data !== 8'hB0 || out_last !== 1'b0) begin
        failures++; $display("FAIL bp_hold%0d got v=%b d=%h l=%b exp v=1 d=b0 l=0", i, out_valid, out_data, out_last);
      end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      $display("pop data=%h last=%0d", out_data, out_last);
      checks++; if (out_data !== ((i == 0) ? 8'hB0 : 8'hA0) || out_last !== (i == 1)) begin
        failures++; $display("FAIL bp_pop%0d got d=%h l=%b exp d=%h l=%b", i, out_data, out_last, ((i == 0) ? 8'hB0 : 8'hA0), (i == 1));
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    push(8'h5A, 1'b1);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    $display("pop data=%h last=%0d", out_data, out_last);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h5A || out_last !== 1'b1) begin failures++; $display("FAIL single_pop got v=%b d=%h l=%b exp v=1 d=5a l=1", out_valid, out_data, out_last); end
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || empty !== 1'b1 || frame_cnt !== 8'd1) begin failures++; $display("FAIL single_after got rdy=%b empty=%b frames=%0d exp 1 1 1", in_ready, empty, frame_cnt); end
  endtask

  task automatic test_reset_drain();
    do_reset();
    push(8'hC1, 1'b1);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    push(8'hD1, 1'b0); push(8'hD2, 1'b0); push(8'hD3, 1'b0); push(8'hD4, 1'b0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (out_data !== 8'hD4) begin failures++; $display("FAIL rstdrain_top got=%h exp=d4", out_data); end
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_data !== 8'hD3 || full !== 1'b0 || split_err !== 1'b1 || frame_cnt !== 8'd1) begin
      failures++; $display("FAIL rstdrain_pre got d=%h full=%b split=%b frames=%0d exp d3 0 1 1", out_data, full, split_err, frame_cnt);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("reset during drain");
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || empty !== 1'b1 || frame_cnt !== 8'd0 || split_err !== 1'b0) begin
      failures++; $display("FAIL rstdrain_post got v=%b rdy=%b empty=%b frames=%0d split=%b exp 0 1 1 0 0", out_valid, in_ready, empty, frame_cnt, split_err);
    end
    push(8'h07, 1'b0); push(8'h08, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      $display("pop data=%h last=%0d", out_data, out_last);
      checks++; if (out_data !== ((i == 0) ? 8'h08 : 8'h07) || out_last !== (i == 1)) begin
        failures++; $display("FAIL rstdrain_pop%0d got d=%h l=%b exp d=%h l=%b", i, out_data, out_last, ((i == 0) ? 8'h08 : 8'h07), (i == 1));
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_hold_off();
    do_reset();
    push(8'h31, 1'b0); push(8'h32, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b0; out_ready = 1'b1;
      $display("pop data=%h last=%0d rdy=%0d", out_data, out_last, in_ready);
      checks++; if (in_ready !== 1'b0 || out_data !== ((i == 0) ? 8'h32 : 8'h31) || out_last !== (i == 1)) begin
        failures++; $display("FAIL hold_pop%0d got rdy=%b d=%h l=%b exp rdy=0 d=%h l=%b", i, in_ready, out_data, out_last, ((i == 0) ? 8'h32 : 8'h31), (i == 1));
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || empty !== 1'b1) begin failures++; $display("FAIL hold_fill got rdy=%b empty=%b exp 1 1", in_ready, empty); end
    push(8'h44, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      $display("pop data=%h last=%0d", out_data, out_last);
      checks++; if (out_data !== ((i == 0) ? 8'h44 : 8'hFF) || out_last !== (i == 1)) begin
        failures++; $display("FAIL hold_pop_next%0d got d=%h l=%b exp d=%h l=%b", i, out_data, out_last, ((i == 0) ? 8'h44 : 8'hFF), (i == 1));
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_split();
    test_backpressure();
    test_single();
    test_reset_drain();
    test_hold_off();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
